// File: rtl/gmii_rx_deframer_pkg.sv
// Shared constants and state encoding for the GMII receive deframer.
package gmii_rx_deframer_pkg;

    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD      = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/gmii_rx_deframer_if.sv
// Byte-wide AXI-Stream carrying deframed payload; no tready, the sink always accepts.
interface gmii_rx_deframer_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser
    );

    modport slave (
        input tdata,
        input tvalid,
        input tlast,
        input tuser
    );

endinterface

// File: rtl/gmii_rx_deframer.sv
// Strips preamble/SFD from the captured GMII receive bus and streams DA..FCS bytes
// with tlast/tuser, flagging preamble errors, runts and oversize frames.
module gmii_rx_deframer
    import gmii_rx_deframer_pkg::*;
#(
    parameter int MAX_LEN   = 1522,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           gmii_rxd,
    input  logic                 gmii_rx_dv,
    input  logic                 gmii_rx_er,
    gmii_rx_deframer_if.master   m_axis,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic                 error_preamble,
    output logic                 error_oversize,
    output logic                 error_runt
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_W = LEN_WIDTH'(MAX_LEN);

    function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
        return (v >= MAX_LEN_W) ? MAX_LEN_W : v + LEN_WIDTH'(1);
    endfunction

    logic [7:0]           rxd_p0;
    logic                 dv_p0;
    logic                 er_p0;
    logic [7:0]           data_p1;
    logic [LEN_WIDTH-1:0] len;
    logic                 bad;
    rx_state_t            state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_p0         <= '0;
            dv_p0          <= 1'b0;
            er_p0          <= 1'b0;
            data_p1        <= '0;
            len            <= '0;
            bad            <= 1'b0;
            state          <= ST_IDLE;
            m_axis.tdata   <= '0;
            m_axis.tvalid  <= 1'b0;
            m_axis.tlast   <= 1'b0;
            m_axis.tuser   <= 1'b0;
            frame_len      <= '0;
            error_preamble <= 1'b0;
            error_oversize <= 1'b0;
            error_runt     <= 1'b0;
        end else begin
            // S0: input capture
            rxd_p0 <= gmii_rxd;
            dv_p0  <= gmii_rx_dv;
            er_p0  <= gmii_rx_er;

            m_axis.tvalid  <= 1'b0;
            m_axis.tlast   <= 1'b0;
            m_axis.tuser   <= 1'b0;
            error_preamble <= 1'b0;
            error_oversize <= 1'b0;
            error_runt     <= 1'b0;

            // S1 / output: FSM acts on the S0 byte
            case (state)
                ST_IDLE: begin
                    if (dv_p0) begin
                        state <= (rxd_p0 == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
                    end
                end

                ST_PREAMBLE: begin
                    if (!dv_p0) begin
                        state          <= ST_IDLE;
                        error_preamble <= 1'b1;
                    end else if (er_p0 || (rxd_p0 != ETH_PREAMBLE && rxd_p0 != ETH_SFD)) begin
                        state          <= ST_DROP;
                        error_preamble <= 1'b1;
                    end else if (rxd_p0 == ETH_SFD) begin
                        state <= ST_PAYLOAD;
                        len   <= '0;
                        bad   <= 1'b0;
                    end
                end

                ST_PAYLOAD: begin
                    if (!dv_p0) begin
                        if (len == '0) begin
                            error_runt <= 1'b1;
                        end else begin
                            m_axis.tvalid <= 1'b1;
                            m_axis.tdata  <= data_p1;
                            m_axis.tlast  <= 1'b1;
                            m_axis.tuser  <= bad;
                            frame_len     <= len;
                        end
                        state <= ST_IDLE;
                    end else if (len == MAX_LEN_W) begin
                        // A byte beyond MAX_LEN arrived: close the frame on the held byte.
                        m_axis.tvalid  <= 1'b1;
                        m_axis.tdata   <= data_p1;
                        m_axis.tlast   <= 1'b1;
                        m_axis.tuser   <= 1'b1;
                        frame_len      <= len;
                        error_oversize <= 1'b1;
                        state          <= ST_DROP;
                    end else begin
                        if (len != '0) begin
                            m_axis.tvalid <= 1'b1;
                            m_axis.tdata  <= data_p1;
                        end
                        data_p1 <= rxd_p0;
                        len     <= sat_inc(len);
                        bad     <= bad | er_p0;
                    end
                end

                ST_DROP: begin
                    if (!dv_p0) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Randomized and directed bench for gmii_rx_deframer against a frame-level reference model.
module tb_gmii_rx_deframer;

    localparam int MAXL = 64;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic [15:0] frame_len;
    logic        e_pre;
    logic        e_ovs;
    logic        e_runt;

    gmii_rx_deframer_if m_axis ();

    gmii_rx_deframer #(
        .MAX_LEN   (MAXL),
        .LEN_WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .gmii_rxd       (rxd),
        .gmii_rx_dv     (dv),
        .gmii_rx_er     (er),
        .m_axis         (m_axis),
        .frame_len      (frame_len),
        .error_preamble (e_pre),
        .error_oversize (e_ovs),
        .error_runt     (e_runt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus: one entry per rising edge
    logic [7:0] st_d  [MAXC];
    logic       st_dv [MAXC];
    logic       st_er [MAXC];
    int         n;

    // Expected output after each rising edge
    logic       x_vld  [MAXC];
    logic [7:0] x_data [MAXC];
    logic       x_last [MAXC];
    logic       x_user [MAXC];
    int         x_len  [MAXC];
    logic       x_pre  [MAXC];
    logic       x_ovs  [MAXC];
    logic       x_runt [MAXC];

    task automatic push(input logic v, input logic e, input logic [7:0] d);
        st_d[n]  = d;
        st_dv[n] = v;
        st_er[n] = e;
        n++;
    endtask

    task automatic idle(input int c);
        repeat (c) push(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame(input int pre, input int plen, input int er_at, input bit inc, input int gap);
        repeat (pre) push(1'b1, 1'b0, 8'h55);
        push(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < plen; i++) begin
            logic [7:0] b;
            b = inc ? i[7:0] : 8'($urandom);
            push(1'b1, (i == er_at), b);
        end
        idle(gap);
    endtask

    // Reference: walk each dv burst, classify it, and place the resulting beats/pulses.
    // A byte sampled at edge t whose arrival decides an event makes it visible after edge t+1.
    task automatic build_model();
        int k;
        int e;
        int i;
        int p;
        int plen;
        int cnt;
        logic uerr;
        for (int c = 0; c < n + 3; c++) begin
            x_vld[c] = 0; x_data[c] = 0; x_last[c] = 0; x_user[c] = 0;
            x_len[c] = 0; x_pre[c] = 0; x_ovs[c] = 0; x_runt[c] = 0;
        end
        k = 0;
        while (k < n) begin
            if (!st_dv[k]) begin
                k++;
                continue;
            end
            e = k;
            while (e + 1 < n && st_dv[e + 1]) e++;
            if (st_d[k] == 8'h55) begin
                i = k + 1;
                while (i <= e && st_d[i] == 8'h55 && !st_er[i]) i++;
                if (i > e) begin
                    x_pre[e + 2] = 1;
                end else if (st_d[i] == 8'hD5 && !st_er[i]) begin
                    p    = i + 1;
                    plen = e - i;
                    if (plen == 0) begin
                        x_runt[e + 2] = 1;
                    end else begin
                        cnt  = (plen > MAXL) ? MAXL : plen;
                        uerr = 0;
                        for (int j = 0; j < cnt; j++) uerr |= st_er[p + j];
                        for (int j = 0; j < cnt; j++) begin
                            x_vld[p + j + 2]  = 1;
                            x_data[p + j + 2] = st_d[p + j];
                            if (j == cnt - 1) begin
                                x_last[p + j + 2] = 1;
                                x_user[p + j + 2] = uerr | (plen > MAXL);
                                x_len[p + j + 2]  = cnt;
                            end
                        end
                        if (plen > MAXL) x_ovs[p + MAXL + 1] = 1;
                    end
                end else begin
                    x_pre[i + 1] = 1;
                end
            end
            k = e + 1;
        end
    endtask

    task automatic run_seg(input string name);
        idle(2);
        build_model();
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                int c;
                c = k - 1;
                check({name, ".tvalid"}, m_axis.tvalid, x_vld[c]);
                check({name, ".err_pre"}, e_pre, x_pre[c]);
                check({name, ".err_ovs"}, e_ovs, x_ovs[c]);
                check({name, ".err_runt"}, e_runt, x_runt[c]);
                if (x_vld[c]) begin
                    check({name, ".tdata"}, m_axis.tdata, x_data[c]);
                    check({name, ".tlast"}, m_axis.tlast, x_last[c]);
                    if (x_last[c]) begin
                        check({name, ".tuser"}, m_axis.tuser, x_user[c]);
                        check({name, ".frame_len"}, frame_len, x_len[c]);
                    end
                end
            end
            if (k < n) begin
                rxd = st_d[k]; dv = st_dv[k]; er = st_er[k];
            end else begin
                rxd = 8'h00; dv = 1'b0; er = 1'b0;
            end
        end
        n = 0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".tvalid"}, m_axis.tvalid, 0);
        check({name, ".tlast"}, m_axis.tlast, 0);
        check({name, ".tuser"}, m_axis.tuser, 0);
        check({name, ".tdata"}, m_axis.tdata, 0);
        check({name, ".frame_len"}, frame_len, 0);
        check({name, ".err_pre"}, e_pre, 0);
        check({name, ".err_ovs"}, e_ovs, 0);
        check({name, ".err_runt"}, e_runt, 0);
    endtask

    initial begin
        n   = 0;
        rst = 1'b1;
        rxd = 8'h00;
        dv  = 1'b0;
        er  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic 64-byte frame, exactly MAX_LEN so no truncation
        frame(7, 64, -1, 1'b1, 3);
        run_seg("basic");
        check("frame_len_hold", frame_len, 64);

        // rx_er mid-frame and on the final byte
        frame(7, 64, 16, 1'b1, 2);
        frame(7, 64, 63, 1'b1, 2);
        frame(3, 20, 0, 1'b0, 2);
        run_seg("rxer");

        // Bad preamble byte, aborted preamble, runt
        repeat (3) push(1'b1, 1'b0, 8'h55);
        push(1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 10; i++) push(1'b1, 1'b0, 8'(i));
        idle(2);
        push(1'b1, 1'b0, 8'h55);
        push(1'b1, 1'b0, 8'h55);
        idle(1);
        push(1'b1, 1'b0, 8'h55);
        push(1'b1, 1'b0, 8'hD5);
        idle(2);
        run_seg("preamble");

        // Oversize and the lengths around MAX_LEN
        frame(7, 100, -1, 1'b1, 3);
        frame(7, MAXL + 1, -1, 1'b0, 2);
        frame(1, MAXL - 1, -1, 1'b0, 2);
        run_seg("oversize");

        // Back-to-back frames with one idle cycle, then bursts without a preamble
        frame(7, 60, -1, 1'b0, 1);
        frame(7, 60, -1, 1'b0, 2);
        for (int i = 0; i < 12; i++) push(1'b1, 1'b0, 8'h10 + 8'(i));
        idle(1);
        push(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 8; i++) push(1'b1, 1'b0, 8'h20 + 8'(i));
        idle(2);
        run_seg("b2b");

        // Randomized mix of frame shapes
        for (int r = 0; r < 40; r++) begin
            int kind;
            int gap;
            kind = $urandom_range(0, 5);
            gap  = $urandom_range(1, 3);
            case (kind)
                0: begin
                    int plen;
                    int er_at;
                    plen  = $urandom_range(1, MAXL + 20);
                    er_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, plen - 1) : -1;
                    frame($urandom_range(1, 7), plen, er_at, 1'b0, gap);
                end
                1: begin
                    repeat ($urandom_range(1, 5)) push(1'b1, 1'b0, 8'h55);
                    push(1'b1, 1'b0, 8'h30 + 8'($urandom_range(0, 15)));
                    repeat ($urandom_range(0, 6)) push(1'b1, 1'b0, 8'($urandom));
                    idle(gap);
                end
                2: frame($urandom_range(1, 7), 0, -1, 1'b0, gap);
                3: begin
                    push(1'b1, 1'b0, 8'h60 + 8'($urandom_range(0, 15)));
                    repeat ($urandom_range(1, 20)) push(1'b1, 1'b0, 8'($urandom));
                    idle(gap);
                end
                4: begin
                    push(1'b1, 1'b0, 8'h55);
                    repeat ($urandom_range(0, 3)) push(1'b1, 1'b0, 8'h55);
                    push(1'b1, 1'b1, 8'h55);
                    frame(2, 10, -1, 1'b0, 0);
                    idle(gap);
                end
                default: begin
                    repeat ($urandom_range(1, 7)) push(1'b1, 1'b0, 8'h55);
                    idle(gap);
                end
            endcase
        end
        run_seg("random");

        // Reset in the middle of a payload, released while dv is still high
        frame(7, 20, -1, 1'b1, 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rxd = st_d[k]; dv = st_dv[k]; er = st_er[k];
        end
        n = 0;
        @(negedge clk);
        rxd = 8'h40;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        rxd = 8'h41;
        for (int i = 0; i < 10; i++) push(1'b1, 1'b0, 8'h42 + 8'(i));
        idle(2);
        frame(7, 60, -1, 1'b1, 3);
        run_seg("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
